// File: rtl/demux_1_4_stream_if.sv
// Stream bundle for the 1-to-4 demultiplexer: one input stream, four output channels.
// Broadcast request line exists only when DEMUX_BROADCAST_EN is defined.
interface demux_1_4_stream_if #(
   parameter int WIDTH = 4
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_data;
   logic [1:0]       in_sel;
`ifdef DEMUX_BROADCAST_EN
   logic             in_bcast;
`endif
   logic [3:0]       out_valid;
   logic [3:0]       out_ready;
   logic [WIDTH-1:0] out_data0;
   logic [WIDTH-1:0] out_data1;
   logic [WIDTH-1:0] out_data2;
   logic [WIDTH-1:0] out_data3;

   // Producer/consumer side of the bundle
   modport master (
      output in_valid,
      input  in_ready,
      output in_data,
      output in_sel,
`ifdef DEMUX_BROADCAST_EN
      output in_bcast,
`endif
      input  out_valid,
      output out_ready,
      input  out_data0,
      input  out_data1,
      input  out_data2,
      input  out_data3
   );

   // Demultiplexer side of the bundle
   modport slave (
      input  in_valid,
      output in_ready,
      input  in_data,
      input  in_sel,
`ifdef DEMUX_BROADCAST_EN
      input  in_bcast,
`endif
      output out_valid,
      input  out_ready,
      output out_data0,
      output out_data1,
      output out_data2,
      output out_data3
   );
endinterface

// File: rtl/demux_1_4_stream.sv
// Registered 1-to-4 stream demultiplexer with a one-entry slot per output channel.
// Optional broadcast to all channels is enabled by defining DEMUX_BROADCAST_EN.
module demux_1_4_stream #(
   parameter int WIDTH = 4
) (
   input  logic                clk,
   input  logic                rst_n,
   demux_1_4_stream_if.slave   s
);

   logic [3:0]       full_q;
   logic [3:0]       full_d;
   logic [WIDTH-1:0] data_q [4];
   logic [WIDTH-1:0] data_d [4];

   logic [3:0]       can_take;
   logic             ready_sel;
   logic             ready_all;
   logic             in_ready;
   logic             acc;
   logic [3:0]       load;
   logic [3:0]       drn;

   // A slot can take a new entry if empty, or if it is draining this same cycle
   assign can_take  = ~full_q | s.out_ready;
   assign ready_sel = can_take[s.in_sel];
   assign ready_all = &can_take;

`ifdef DEMUX_BROADCAST_EN
   assign in_ready = s.in_bcast ? ready_all : ready_sel;
`else
   assign in_ready = ready_sel;
`endif

   assign acc = s.in_valid & in_ready;
   assign drn = full_q & s.out_ready;

   always_comb begin
      load = 4'b0000;
      for (int n = 0; n < 4; n++) begin
`ifdef DEMUX_BROADCAST_EN
         load[n] = acc & (s.in_bcast | (s.in_sel == 2'(n)));
`else
         load[n] = acc & (s.in_sel == 2'(n));
`endif
      end
   end

   // Load wins over drain so a slot can be emptied and refilled in one cycle
   always_comb begin
      full_d = full_q;
      for (int n = 0; n < 4; n++) begin
         data_d[n] = data_q[n];
         if (load[n]) begin
            full_d[n] = 1'b1;
            data_d[n] = s.in_data;
         end else if (drn[n]) begin
            full_d[n] = 1'b0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         full_q <= 4'b0000;
         for (int n = 0; n < 4; n++) begin
            data_q[n] <= '0;
         end
      end else begin
         full_q <= full_d;
         for (int n = 0; n < 4; n++) begin
            data_q[n] <= data_d[n];
         end
      end
   end

   assign s.in_ready  = in_ready;
   assign s.out_valid = full_q;
   assign s.out_data0 = data_q[0];
   assign s.out_data1 = data_q[1];
   assign s.out_data2 = data_q[2];
   assign s.out_data3 = data_q[3];

endmodule

// File: tb/tb_demux_1_4_stream.sv
// Directed self-checking bench for demux_1_4_stream (routing, back-pressure, full rate, reset).
module tb_demux_1_4_stream;

   logic clk;
   logic rst_n;
   int   vectors;
   int   miscompares;

   demux_1_4_stream_if #(.WIDTH(4)) bus ();

   demux_1_4_stream #(.WIDTH(4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .s     (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: time limit expired, summary not reached");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      bus.in_valid  = 1'b0;
      bus.in_data   = 4'h0;
      bus.in_sel    = 2'd0;
      bus.out_ready = 4'b0000;
`ifdef DEMUX_BROADCAST_EN
      bus.in_bcast  = 1'b0;
`endif
      #12;
      vectors++;
      if (bus.out_valid !== 4'b0000) begin
         miscompares++;
         $display("FAIL reset_out_valid: got %b want 0000", bus.out_valid);
      end
      vectors++;
      if ({bus.out_data3, bus.out_data2, bus.out_data1, bus.out_data0} !== 16'h0000) begin
         miscompares++;
         $display("FAIL reset_out_data: got %h want 0000",
                  {bus.out_data3, bus.out_data2, bus.out_data1, bus.out_data0});
      end
      for (int i = 0; i < 4; i++) begin
         bus.in_sel = 2'(i);
         #1;
         vectors++;
         if (bus.in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_in_ready sel=%0d: got %b want 1", i, bus.in_ready);
         end
      end
      @(negedge clk);
      rst_n = 1'b1;
      step();
   endtask

   task automatic test_routing();
      bus.in_valid  = 1'b1;
      bus.in_sel    = 2'd2;
      bus.in_data   = 4'hA;
      bus.out_ready = 4'b0000;
      #1;
      vectors++;
      if (bus.in_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL route_ready_empty: got %b want 1", bus.in_ready);
      end
      step();
      bus.in_valid = 1'b0;
      #1;
      vectors++;
      if (bus.out_valid !== 4'b0100) begin
         miscompares++;
         $display("FAIL route_out_valid: got %b want 0100", bus.out_valid);
      end
      vectors++;
      if (bus.out_data2 !== 4'hA) begin
         miscompares++;
         $display("FAIL route_out_data2: got %h want a", bus.out_data2);
      end
      bus.in_sel = 2'd2;
      #1;
      vectors++;
      if (bus.in_ready !== 1'b0) begin
         miscompares++;
         $display("FAIL route_ready_full_sel2: got %b want 0", bus.in_ready);
      end
      bus.in_sel = 2'd0;
      #1;
      vectors++;
      if (bus.in_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL route_ready_empty_sel0: got %b want 1", bus.in_ready);
      end
   endtask

   task automatic test_backpressure();
      bus.in_valid  = 1'b1;
      bus.in_sel    = 2'd1;
      bus.in_data   = 4'h7;
      bus.out_ready = 4'b0000;
      step();
      bus.in_sel    = 2'd3;
      bus.in_data   = 4'h3;
      bus.out_ready = 4'b1000;
      #1;
      vectors++;
      if (bus.in_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL bp_ready_ch3: got %b want 1", bus.in_ready);
      end
      step();
      bus.in_valid = 1'b0;
      #1;
      vectors++;
      if (bus.out_data3 !== 4'h3) begin
         miscompares++;
         $display("FAIL bp_out_data3: got %h want 3", bus.out_data3);
      end
      vectors++;
      if (bus.out_valid !== 4'b1110) begin
         miscompares++;
         $display("FAIL bp_out_valid: got %b want 1110", bus.out_valid);
      end
      vectors++;
      if (bus.out_data1 !== 4'h7) begin
         miscompares++;
         $display("FAIL bp_ch1_hold: got %h want 7", bus.out_data1);
      end
      step();
      vectors++;
      if (bus.out_valid !== 4'b0110) begin
         miscompares++;
         $display("FAIL bp_ch3_drain: got %b want 0110", bus.out_valid);
      end
      vectors++;
      if (bus.out_data3 !== 4'h3) begin
         miscompares++;
         $display("FAIL bp_ch3_data_kept: got %h want 3", bus.out_data3);
      end
   endtask

   task automatic test_stall_and_refill();
      bus.out_ready = 4'b0000;
      bus.in_valid  = 1'b1;
      bus.in_sel    = 2'd1;
      bus.in_data   = 4'h9;
      #1;
      vectors++;
      if (bus.in_ready !== 1'b0) begin
         miscompares++;
         $display("FAIL stall_ready: got %b want 0", bus.in_ready);
      end
      step();
      vectors++;
      if (bus.out_data1 !== 4'h7 || bus.out_valid !== 4'b0110) begin
         miscompares++;
         $display("FAIL stall_hold: got data1=%h valid=%b want data1=7 valid=0110",
                  bus.out_data1, bus.out_valid);
      end
      bus.out_ready = 4'b0010;
      #1;
      vectors++;
      if (bus.in_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL refill_ready: got %b want 1", bus.in_ready);
      end
      step();
      bus.in_valid  = 1'b0;
      bus.out_ready = 4'b0000;
      #1;
      vectors++;
      if (bus.out_data1 !== 4'h9 || bus.out_valid !== 4'b0110) begin
         miscompares++;
         $display("FAIL refill_result: got data1=%h valid=%b want data1=9 valid=0110",
                  bus.out_data1, bus.out_valid);
      end
   endtask

   task automatic test_full_rate();
      bus.in_sel    = 2'd0;
      bus.out_ready = 4'b0001;
      bus.in_valid  = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         bus.in_data = 4'(i);
         #1;
         vectors++;
         if (bus.in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL rate_ready[%0d]: got %b want 1", i, bus.in_ready);
         end
         step();
         vectors++;
         if (bus.out_data0 !== 4'(i) || bus.out_valid[0] !== 1'b1) begin
            miscompares++;
            $display("FAIL rate_out[%0d]: got data0=%h valid0=%b want data0=%h valid0=1",
                     i, bus.out_data0, bus.out_valid[0], 4'(i));
         end
      end
      bus.in_valid = 1'b0;
      step();
      vectors++;
      if (bus.out_valid !== 4'b0110) begin
         miscompares++;
         $display("FAIL rate_final_drain: got %b want 0110", bus.out_valid);
      end
   endtask

   task automatic test_all_full();
      bus.out_ready = 4'b0000;
      bus.in_valid  = 1'b1;
      bus.in_sel    = 2'd0;
      bus.in_data   = 4'hB;
      step();
      bus.in_sel    = 2'd3;
      bus.in_data   = 4'hC;
      step();
      vectors++;
      if (bus.out_valid !== 4'b1111) begin
         miscompares++;
         $display("FAIL full_fill: got %b want 1111", bus.out_valid);
      end
      for (int i = 0; i < 4; i++) begin
         bus.in_sel = 2'(i);
         #1;
         vectors++;
         if (bus.in_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL full_ready sel=%0d: got %b want 0", i, bus.in_ready);
         end
      end
      bus.in_sel  = 2'd0;
      bus.in_data = 4'hF;
      step();
      bus.in_valid = 1'b0;
      vectors++;
      if ({bus.out_data3, bus.out_data2, bus.out_data1, bus.out_data0} !== 16'hCA9B
          || bus.out_valid !== 4'b1111) begin
         miscompares++;
         $display("FAIL full_no_change: got data=%h valid=%b want data=ca9b valid=1111",
                  {bus.out_data3, bus.out_data2, bus.out_data1, bus.out_data0}, bus.out_valid);
      end
   endtask

   task automatic test_reset_mid();
      #2;
      rst_n = 1'b0;
      #1;
      vectors++;
      if (bus.out_valid !== 4'b0000) begin
         miscompares++;
         $display("FAIL midrst_valid: got %b want 0000", bus.out_valid);
      end
      vectors++;
      if ({bus.out_data3, bus.out_data2, bus.out_data1, bus.out_data0} !== 16'h0000) begin
         miscompares++;
         $display("FAIL midrst_data: got %h want 0000",
                  {bus.out_data3, bus.out_data2, bus.out_data1, bus.out_data0});
      end
      #1;
      rst_n = 1'b1;
      step();
      vectors++;
      if (bus.out_valid !== 4'b0000) begin
         miscompares++;
         $display("FAIL midrst_after: got %b want 0000", bus.out_valid);
      end
   endtask

`ifdef DEMUX_BROADCAST_EN
   task automatic test_broadcast();
      bus.out_ready = 4'b0000;
      bus.in_bcast  = 1'b0;
      bus.in_valid  = 1'b1;
      bus.in_sel    = 2'd2;
      bus.in_data   = 4'h8;
      step();
      bus.in_bcast = 1'b1;
      bus.in_sel   = 2'd0;
      bus.in_data  = 4'h5;
      #1;
      vectors++;
      if (bus.in_ready !== 1'b0) begin
         miscompares++;
         $display("FAIL bcast_blocked: got %b want 0", bus.in_ready);
      end
      step();
      vectors++;
      if (bus.out_valid !== 4'b0100) begin
         miscompares++;
         $display("FAIL bcast_no_accept: got %b want 0100", bus.out_valid);
      end
      bus.out_ready = 4'b0100;
      #1;
      vectors++;
      if (bus.in_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL bcast_ready: got %b want 1", bus.in_ready);
      end
      step();
      bus.in_valid  = 1'b0;
      bus.in_bcast  = 1'b0;
      bus.out_ready = 4'b0000;
      #1;
      vectors++;
      if (bus.out_valid !== 4'b1111
          || {bus.out_data3, bus.out_data2, bus.out_data1, bus.out_data0} !== 16'h5555) begin
         miscompares++;
         $display("FAIL bcast_result: got valid=%b data=%h want valid=1111 data=5555",
                  bus.out_valid, {bus.out_data3, bus.out_data2, bus.out_data1, bus.out_data0});
      end
   endtask
`endif

   initial begin
      vectors     = 0;
      miscompares = 0;
      test_reset();
      test_routing();
      test_backpressure();
      test_stall_and_refill();
      test_full_rate();
      test_all_full();
      test_reset_mid();
`ifdef DEMUX_BROADCAST_EN
      test_broadcast();
`endif
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
